// File: rtl/egress_scheduler.sv
// rtl/egress_scheduler.sv - SP/WRR packet egress scheduler; SCHED_STATS_EN adds per-priority grant counters
module egress_scheduler #(
    parameter int num_of_priorities = 8,
    parameter int weight_width = 4,
    localparam int pri_width = $clog2(num_of_priorities)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      sp0_wrr1,
    input  logic [num_of_priorities-1:0]              prepared,
    input  logic [num_of_priorities*weight_width-1:0] weight,
    input  logic                                      req_ready,
    input  logic                                      pkt_eop,
    output logic [num_of_priorities-1:0]              grant,
    output logic [pri_width-1:0]                      grant_pri,
    output logic                                      grant_vld,
    output logic                                      busy
`ifdef SCHED_STATS_EN
    ,
    input  logic [pri_width-1:0]                      stat_sel,
    output logic [31:0]                               stat_cnt
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]                   state;
    logic                         mode_r;
    logic [pri_width-1:0]         rr_ptr;
    // Credits are kept as "used" counts so reset loads a constant: credit = weight - used.
    logic [weight_width-1:0]      used [num_of_priorities];
    logic [num_of_priorities-1:0] eligible;
    logic [num_of_priorities-1:0] weighted;
    logic                         sp_found;
    logic                         wrr_found;
    logic                         win_found;
    logic                         refill;
    logic                         take;
    logic [pri_width-1:0]         sp_idx;
    logic [pri_width-1:0]         wrr_idx;
    logic [pri_width-1:0]         win_idx;
    logic [weight_width-1:0]      cur_weight;
    logic [weight_width-1:0]      used_next;
    int                           scan_idx;

    always_comb begin
        eligible = '0;
        weighted = '0;
        for (int i = 0; i < num_of_priorities; i++) begin
            eligible[i] = prepared[i] && (used[i] < weight[i*weight_width +: weight_width]);
            weighted[i] = prepared[i] && (weight[i*weight_width +: weight_width] != '0);
        end
        refill = (eligible == '0) && (weighted != '0);
    end

    always_comb begin
        sp_found = 1'b0;
        sp_idx   = '0;
        for (int i = 0; i < num_of_priorities; i++) begin
            if (prepared[i]) begin
                sp_found = 1'b1;
                sp_idx   = pri_width'(i);
            end
        end
    end

    // Walk the scan order backwards so the last hit is the first eligible one from rr_ptr downward.
    always_comb begin
        wrr_found = 1'b0;
        wrr_idx   = '0;
        scan_idx  = 0;
        for (int k = num_of_priorities - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) - k;
            if (scan_idx < 0) begin
                scan_idx = scan_idx + num_of_priorities;
            end
            if (eligible[scan_idx]) begin
                wrr_found = 1'b1;
                wrr_idx   = pri_width'(scan_idx);
            end
        end
    end

    assign win_found  = sp0_wrr1 ? wrr_found : sp_found;
    assign win_idx    = sp0_wrr1 ? wrr_idx : sp_idx;
    assign take       = (state == IDLE) && req_ready && win_found;
    assign cur_weight = weight[int'(grant_pri)*weight_width +: weight_width];
    assign used_next  = used[grant_pri] + weight_width'(1);
    assign busy       = (state == GRANT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            rr_ptr    <= pri_width'(num_of_priorities - 1);
            grant     <= '0;
            grant_pri <= '0;
            grant_vld <= 1'b0;
            for (int i = 0; i < num_of_priorities; i++) begin
                used[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= GRANT;
                        mode_r    <= sp0_wrr1;
                        grant     <= num_of_priorities'(1) << win_idx;
                        grant_pri <= win_idx;
                        grant_vld <= 1'b1;
                    end else if (sp0_wrr1 && refill) begin
                        for (int i = 0; i < num_of_priorities; i++) begin
                            used[i] <= '0;
                        end
                    end
                end
                default: begin
                    if (pkt_eop) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_pri <= '0;
                        grant_vld <= 1'b0;
                        if (mode_r) begin
                            used[grant_pri] <= used_next;
                            if (used_next >= cur_weight) begin
                                rr_ptr <= (grant_pri == '0) ? pri_width'(num_of_priorities - 1)
                                                            : grant_pri - pri_width'(1);
                            end else begin
                                rr_ptr <= grant_pri;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] cnt [num_of_priorities];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < num_of_priorities; i++) begin
                cnt[i] <= '0;
            end
        end else if (take && (cnt[win_idx] != 32'hFFFF_FFFF)) begin
            cnt[win_idx] <= cnt[win_idx] + 32'd1;
        end
    end

    assign stat_cnt = cnt[stat_sel];
`endif

endmodule

// File: tb/tb_egress_scheduler.sv
// tb/tb_egress_scheduler.sv - scoreboard bench for egress_scheduler
module tb_egress_scheduler;

    logic        clk;
    logic        rst;
    logic        sp0_wrr1;
    logic [7:0]  prepared;
    logic [31:0] weight;
    logic        req_ready;
    logic        pkt_eop;
    logic [7:0]  grant;
    logic [2:0]  grant_pri;
    logic        grant_vld;
    logic        busy;
`ifdef SCHED_STATS_EN
    logic [2:0]  stat_sel;
    logic [31:0] stat_cnt;
`endif

    int checks;
    int failures;
    int exp_q[$];
    logic prev_vld;

    egress_scheduler dut (
        .clk(clk),
        .rst(rst),
        .sp0_wrr1(sp0_wrr1),
        .prepared(prepared),
        .weight(weight),
        .req_ready(req_ready),
        .pkt_eop(pkt_eop),
        .grant(grant),
        .grant_pri(grant_pri),
        .grant_vld(grant_vld),
        .busy(busy)
`ifdef SCHED_STATS_EN
        ,
        .stat_sel(stat_sel),
        .stat_cnt(stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each rising grant_vld pops the next expected priority.
    always @(negedge clk) begin
        if (grant_vld && !prev_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_grant got pri=%0d grant=%h, required no grant", grant_pri, grant);
            end else begin
                int e;
                logic [7:0] oh;
                e  = exp_q.pop_front();
                oh = 8'd1 << e;
                if (grant_pri !== 3'(e) || grant !== oh || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL sb_grant got pri=%0d grant=%h busy=%b, required pri=%0d grant=%h busy=1",
                             grant_pri, grant, busy, e, oh);
                end
            end
        end
        checks++;
        if ((grant_vld && ($countones(grant) != 1 || grant !== (8'd1 << grant_pri))) ||
            (!grant_vld && grant !== 8'h00)) begin
            failures++;
            $display("FAIL onehot got vld=%b grant=%h pri=%0d, required one-hot iff vld", grant_vld, grant, grant_pri);
        end
        prev_vld = grant_vld;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_vld(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (grant_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        pkt_eop = 1'b1;
        @(negedge clk);
        pkt_eop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 8'h00 || grant_pri !== 3'd0 || grant_vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got grant=%h pri=%0d vld=%b busy=%b, required all 0", grant, grant_pri, grant_vld, busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sp();
        prepared  = 8'b1000_0010;
        req_ready = 1'b1;
        exp_q.push_back(7);
        @(negedge clk);
        checks++;
        if (grant !== 8'h80 || grant_pri !== 3'd7 || grant_vld !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL sp_latency got grant=%h pri=%0d vld=%b busy=%b, required 80/7/1/1", grant, grant_pri, grant_vld, busy);
        end
        pkt_eop = 1'b1;
        @(negedge clk);
        pkt_eop   = 1'b0;
        prepared  = 8'h00;
        req_ready = 1'b0;
        checks++;
        if (grant_vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sp_release got vld=%b busy=%b, required 0/0", grant_vld, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_wrr();
        int seq[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        bit ok;
        sp0_wrr1  = 1'b1;
        prepared  = 8'b0000_0011;
        req_ready = 1'b1;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        for (int n = 0; n < 8; n++) begin
            wait_vld(10, ok);
            checks++;
            if (!ok || grant_pri !== 3'(seq[n])) begin
                failures++;
                $display("FAIL wrr_seq[%0d] got vld=%b pri=%0d, required pri=%0d", n, ok, grant_pri, seq[n]);
            end
            @(negedge clk);
            pkt_eop = 1'b1;
            @(negedge clk);
            pkt_eop = 1'b0;
            if (n == 7) begin
                req_ready = 1'b0;
                prepared  = 8'h00;
            end
            checks++;
            if (grant_vld !== 1'b0) begin
                failures++;
                $display("FAIL wrr_gap[%0d] got vld=%b, required 0 after eop", n, grant_vld);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_weight();
        bit seen;
        bit ok;
        sp0_wrr1  = 1'b1;
        prepared  = 8'b0000_0100;
        req_ready = 1'b1;
        seen      = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (grant_vld) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL zero_weight_idle got grant_vld=1, required 0 for 100 cycles");
        end
        sp0_wrr1 = 1'b0;
        exp_q.push_back(2);
        wait_vld(2, ok);
        checks++;
        if (!ok || grant_pri !== 3'd2) begin
            failures++;
            $display("FAIL zero_weight_sp got vld=%b pri=%0d, required 1/2", ok, grant_pri);
        end
        prepared  = 8'h00;
        req_ready = 1'b0;
        pulse_eop();
        @(negedge clk);
    endtask

    task automatic test_hold();
        bit ok;
        bit held;
        sp0_wrr1  = 1'b0;
        prepared  = 8'b0010_0000;
        req_ready = 1'b1;
        exp_q.push_back(5);
        wait_vld(5, ok);
        held = ok;
        for (int i = 0; i < 6; i++) begin
            sp0_wrr1    = ~sp0_wrr1;
            prepared[5] = 1'b0;
            prepared[7] = i[0];
            req_ready   = ~req_ready;
            @(negedge clk);
            if (grant !== 8'h20 || grant_vld !== 1'b1 || busy !== 1'b1) held = 1'b0;
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL hold_grant got grant=%h vld=%b, required 20/1 until eop", grant, grant_vld);
        end
        sp0_wrr1  = 1'b0;
        prepared  = 8'h00;
        req_ready = 1'b0;
        pkt_eop   = 1'b1;
        @(negedge clk);
        pkt_eop = 1'b0;
        checks++;
        if (grant_vld !== 1'b0 || grant !== 8'h00) begin
            failures++;
            $display("FAIL hold_release got vld=%b grant=%h, required 0/00", grant_vld, grant);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        sp0_wrr1  = 1'b1;
        prepared  = 8'b1010_0000;
        req_ready = 1'b1;
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(5);
        for (int n = 0; n < 2; n++) begin
            wait_vld(10, ok);
            pulse_eop();
        end
        wait_vld(10, ok);
        checks++;
        if (!ok || grant_pri !== 3'd5) begin
            failures++;
            $display("FAIL wrr_advance got vld=%b pri=%0d, required 1/5", ok, grant_pri);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 8'h00 || grant_vld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got grant=%h vld=%b busy=%b, required 00/0/0", grant, grant_vld, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(7);
        wait_vld(10, ok);
        checks++;
        if (!ok || grant_pri !== 3'd7) begin
            failures++;
            $display("FAIL reset_restart got vld=%b pri=%0d, required 1/7", ok, grant_pri);
        end
        prepared  = 8'h00;
        req_ready = 1'b0;
        pulse_eop();
        sp0_wrr1 = 1'b0;
        @(negedge clk);
    endtask

`ifdef SCHED_STATS_EN
    task automatic test_stats();
        bit ok;
        sp0_wrr1  = 1'b0;
        prepared  = 8'b0000_1000;
        req_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(3);
            wait_vld(10, ok);
            pulse_eop();
        end
        prepared  = 8'h00;
        req_ready = 1'b0;
        @(negedge clk);
        stat_sel = 3'd3;
        #1;
        checks++;
        if (stat_cnt !== 32'd5) begin
            failures++;
            $display("FAIL stat_pri3 got %0d, required 5", stat_cnt);
        end
        stat_sel = 3'd4;
        #1;
        checks++;
        if (stat_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stat_pri4 got %0d, required 0", stat_cnt);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        prev_vld  = 1'b0;
        rst       = 1'b0;
        sp0_wrr1  = 1'b0;
        prepared  = 8'h00;
        req_ready = 1'b0;
        pkt_eop   = 1'b0;
        weight    = {4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd0, 4'd3, 4'd1};
`ifdef SCHED_STATS_EN
        stat_sel  = 3'd0;
`endif
        test_reset();
        test_sp();
        test_wrr();
        test_zero_weight();
        test_hold();
        test_async_reset();
`ifdef SCHED_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
